// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and encodings for the systolic MAC array sequencer.
package mac_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        DRAIN,
        FLUSH,
        DONE
    } state_e;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/mac_seq_ctrl_beat_cnt.sv
// Loadable down-counter; tc flags the count resting at zero.
module seq_beat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Tile sequencer for the systolic MAC array: kernel load, execute, skew drain
// and (output-stationary only) per-column psum flush.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int LEN_BW    = 8,
    parameter int DRAIN_CYC = ROW + COL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [LEN_BW-1:0] k_len,
    input  logic              l0_empty,
    input  logic              ofifo_full,
    output logic              l0_rd,
    output logic [1:0]        inst_w,
    output logic              format,
    output logic              overwrite,
    output logic [COL-1:0]    flush,
    output logic              busy,
    output logic              done
);

    localparam int LD_W = $clog2(ROW + 1);
    localparam int DR_W = $clog2(DRAIN_CYC + 1);
    localparam int FL_W = $clog2(COL);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [LEN_BW-1:0]   klen_q, klen_d;
    logic [1:0]          inst_q, inst_d;
    logic                ovw_q, ovw_d;
    logic [COL-1:0]      flush_q, flush_d;

    logic                accept, fire_load, fire_exec, flush_go;
    logic [LD_W-1:0]     ld_cnt;
    logic [LEN_BW-1:0]   ex_cnt;
    logic [DR_W-1:0]     dr_cnt;
    logic [FL_W-1:0]     fl_cnt, fl_idx;
    logic                ld_tc, ex_tc, dr_tc, fl_tc;
    logic [LD_W+DR_W-1:0] unused_cnt;

    assign accept    = (state_q == IDLE) && start;
    assign fire_load = (state_q == LOAD) && !l0_empty;
    assign fire_exec = (state_q == EXEC) && !l0_empty && !ofifo_full;
    assign flush_go  = (state_q == FLUSH) && !ofifo_full;

    // Every counter is preloaded with its count minus one on the accepted
    // start; each only moves in its own state, so one load strobe suffices.
    seq_beat_cnt #(.W(LD_W)) u_ld_cnt (
        .clk(clk), .reset(reset), .load(accept), .load_val(LD_W'(ROW - 1)),
        .en(fire_load), .cnt(ld_cnt), .tc(ld_tc)
    );
    seq_beat_cnt #(.W(LEN_BW)) u_ex_cnt (
        .clk(clk), .reset(reset), .load(accept), .load_val(k_len - LEN_BW'(1)),
        .en(fire_exec), .cnt(ex_cnt), .tc(ex_tc)
    );
    seq_beat_cnt #(.W(DR_W)) u_dr_cnt (
        .clk(clk), .reset(reset), .load(accept), .load_val(DR_W'(DRAIN_CYC - 1)),
        .en(state_q == DRAIN), .cnt(dr_cnt), .tc(dr_tc)
    );
    seq_beat_cnt #(.W(FL_W)) u_fl_cnt (
        .clk(clk), .reset(reset), .load(accept), .load_val(FL_W'(COL - 1)),
        .en(flush_go), .cnt(fl_cnt), .tc(fl_tc)
    );

    assign unused_cnt = {ld_cnt, dr_cnt};
    assign fl_idx     = FL_W'(COL - 1) - fl_cnt;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        klen_d  = klen_q;
        inst_d  = {fire_exec, fire_load};
        ovw_d   = fire_exec && (mode_q == MODE_OS) && (ex_cnt == klen_q - LEN_BW'(1));
        flush_d = flush_go ? (COL'(1) << fl_idx) : '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    klen_d = k_len;
                    if (mode == MODE_WS)   state_d = LOAD;
                    else if (k_len == '0)  state_d = DRAIN;
                    else                   state_d = EXEC;
                end
            end
            LOAD: begin
                if (fire_load && ld_tc) state_d = (klen_q == '0) ? DRAIN : EXEC;
            end
            EXEC: begin
                if (fire_exec && ex_tc) state_d = DRAIN;
            end
            DRAIN: begin
                if (dr_tc) state_d = (mode_q == MODE_OS) ? FLUSH : DONE;
            end
            FLUSH: begin
                if (flush_go && fl_tc) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_WS;
            klen_q  <= '0;
            inst_q  <= INST_NOP;
            ovw_q   <= 1'b0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            klen_q  <= klen_d;
            inst_q  <= inst_d;
            ovw_q   <= ovw_d;
            flush_q <= flush_d;
        end
    end

    assign l0_rd     = fire_load || fire_exec;
    assign inst_w    = inst_q;
    assign overwrite = ovw_q;
    assign flush     = flush_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign format    = (state_q != IDLE) ? mode_q : MODE_WS;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: directed tiles push expected beats,
// flush strobes and busy lengths; a negedge monitor pops and compares.
module tb_mac_seq_ctrl;
    import mac_seq_ctrl_pkg::*;

    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int LEN_BW = 8;
    localparam int DRAIN  = ROW + COL;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mode;
    logic [LEN_BW-1:0] k_len;
    logic              l0_empty;
    logic              ofifo_full;
    logic              l0_rd;
    logic [1:0]        inst_w;
    logic              format;
    logic              overwrite;
    logic [COL-1:0]    flush;
    logic              busy;
    logic              done;

    logic [14:0]       all_out;
    assign all_out = {l0_rd, inst_w, format, overwrite, flush, busy, done};

    mac_seq_ctrl #(.ROW(ROW), .COL(COL), .LEN_BW(LEN_BW), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .k_len(k_len),
        .l0_empty(l0_empty), .ofifo_full(ofifo_full), .l0_rd(l0_rd),
        .inst_w(inst_w), .format(format), .overwrite(overwrite), .flush(flush),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // expected {inst_w, overwrite, format} per non-NOP beat
    logic [3:0]     exp_inst[$];
    logic [COL-1:0] exp_flush[$];
    int             exp_done[$];

    int             busy_len = 0;
    logic [3:0]     mon_inst, mon_ei;
    logic [COL-1:0] mon_ef;
    int             mon_ed;

    always @(negedge clk) begin
        if (busy) busy_len++;
        else      busy_len = 0;
        if (inst_w != INST_NOP) begin
            mon_inst = {inst_w, overwrite, format};
            n_cmp++;
            if (exp_inst.size() == 0) begin
                n_err++;
                $display("FAIL inst_extra: got %b, expected no beat", mon_inst);
            end else begin
                mon_ei = exp_inst.pop_front();
                if (mon_inst !== mon_ei) begin
                    n_err++;
                    $display("FAIL inst_beat: got {inst,ovw,fmt}=%b expected %b", mon_inst, mon_ei);
                end
            end
        end
        if (flush != '0) begin
            n_cmp++;
            if (exp_flush.size() == 0) begin
                n_err++;
                $display("FAIL flush_extra: got 0x%02h, expected none", flush);
            end else begin
                mon_ef = exp_flush.pop_front();
                if (flush !== mon_ef) begin
                    n_err++;
                    $display("FAIL flush_strobe: got 0x%02h expected 0x%02h", flush, mon_ef);
                end
            end
        end
        if (done) begin
            n_cmp++;
            if (exp_done.size() == 0) begin
                n_err++;
                $display("FAIL done_extra: got done after %0d busy cycles, expected none", busy_len);
            end else begin
                mon_ed = exp_done.pop_front();
                if (busy_len != mon_ed) begin
                    n_err++;
                    $display("FAIL tile_len: got %0d busy cycles expected %0d", busy_len, mon_ed);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Busy length counts every non-IDLE cycle including DONE; stall cycles add one each.
    task automatic push_tile(input logic m, input int k, input int extra);
        logic [COL-1:0] one;
        one = 1;
        if (m == MODE_WS) begin
            for (int i = 0; i < ROW; i++) exp_inst.push_back({INST_LOAD, 1'b0, 1'b0});
            for (int i = 0; i < k; i++)   exp_inst.push_back({INST_EXEC, 1'b0, 1'b0});
            exp_done.push_back(ROW + k + DRAIN + 1 + extra);
        end else begin
            for (int i = 0; i < k; i++)   exp_inst.push_back({INST_EXEC, (i == 0), 1'b1});
            for (int i = 0; i < COL; i++) exp_flush.push_back(one << i);
            exp_done.push_back(k + DRAIN + COL + 1 + extra);
        end
    endtask

    // Returns one cycle after acceptance, at posedge+1 of the first busy cycle.
    task automatic start_tile(input logic m, input int k);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        k_len = LEN_BW'(k);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, budget);
        end
        @(posedge clk); #1;
        check({name, "_idle"}, {busy, done, format, overwrite, flush}, 0);
    endtask

    logic pe [11] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    logic pf [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0; k_len = '0;
        l0_empty = 1'b0; ofifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_out, 0);
        reset = 1'b1;

        push_tile(MODE_WS, 4, 0);
        start_tile(MODE_WS, 4);
        wait_done("ws_k4", 100);

        push_tile(MODE_OS, 3, 0);
        start_tile(MODE_OS, 3);
        wait_done("os_k3", 100);

        // 2 empty, 3 full-only and 1 both-high stall cycles in EXEC
        push_tile(MODE_OS, 5, 6);
        start_tile(MODE_OS, 5);
        for (int j = 0; j < 11; j++) begin
            l0_empty   = pe[j];
            ofifo_full = pf[j];
            @(posedge clk); #1;
        end
        l0_empty = 1'b0; ofifo_full = 1'b0;
        wait_done("os_stall", 100);

        // FLUSH starts 18 cycles after accept; hold column 2 for two cycles
        push_tile(MODE_OS, 1, 2);
        start_tile(MODE_OS, 1);
        repeat (19) @(posedge clk);
        #1;
        ofifo_full = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ofifo_full = 1'b0;
        wait_done("os_flush_bp", 100);

        push_tile(MODE_OS, 0, 0);
        start_tile(MODE_OS, 0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; mode = MODE_WS; k_len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("os_k0_busy_start", 100);
        repeat (40) @(posedge clk);
        #1;
        check("no_second_tile", busy, 0);

        push_tile(MODE_WS, 0, 0);
        start_tile(MODE_WS, 0);
        wait_done("ws_k0", 100);

        // abort an OS tile mid-EXEC
        push_tile(MODE_OS, 10, 0);
        start_tile(MODE_OS, 10);
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort_busy", {busy, l0_rd, inst_w}, 4'b1110);
        #2;
        reset = 1'b0;
        exp_inst.delete();
        exp_flush.delete();
        exp_done.delete();
        #1;
        check("async_reset_outputs", all_out, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("post_reset_idle", {busy, l0_rd, format}, 0);

        push_tile(MODE_WS, 2, 0);
        start_tile(MODE_WS, 2);
        wait_done("ws_after_reset", 100);

        check("queues_drained", exp_inst.size() + exp_flush.size() + exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
